// File: rtl/milano_bus_pkg.sv
// Shared bus types for the milano core memory-port arbiter: response owner
// tags and the per-slot record carried through the read-response pipeline.
package milano_bus_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
    } resp_slot_t;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Fixed-latency response tracker: follows each granted access for MEM_LAT
// cycles and steers the returning memory datum to the requester that issued it.
module mem_arb_resp_pipe
    import milano_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  resp_slot_t        push_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o
);

    resp_slot_t slot_p [MEM_LAT];
    resp_slot_t head;

    // Stage p0 captures the grant; each later stage is one more cycle of memory latency.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                slot_p[i] <= '0;
            end
        end else begin
            slot_p[0] <= push_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                slot_p[i] <= slot_p[i-1];
            end
        end
    end

    // The clear also masks the head so nothing leaks out during the clear cycle itself.
    always_comb begin
        head           = slot_p[MEM_LAT-1];
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        instr_rdata_o  = '0;
        data_rdata_o   = '0;
        if (head.valid && !clr_i) begin
            if (head.owner == OWN_INSTR) begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = mem_rdata_i;
            end else begin
                data_rvalid_o = 1'b1;
                if (!head.is_write) begin
                    data_rdata_o = mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store with data priority
// and a bounded fetch wait. Optional perf counters: define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import milano_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         conflict_cnt_o,
    output logic [31:0]         instr_stall_cnt_o
`endif
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       fetch_forced;
    resp_slot_t push_slot;

    // Data wins unless fetch has already lost MAX_WAIT times in a row.
    always_comb begin
        instr_gnt_o  = 1'b0;
        data_gnt_o   = 1'b0;
        fetch_forced = instr_req_i && (wait_cnt == WAIT_MAX);
        if (!rst_i) begin
            if (data_req_i && !fetch_forced) begin
                data_gnt_o = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = instr_gnt_o | data_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (data_gnt_o) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (instr_gnt_o) begin
            mem_be_o   = '1;
            mem_addr_o = instr_addr_i;
        end
    end

    always_comb begin
        push_slot.valid    = mem_en_o;
        push_slot.owner    = data_gnt_o ? OWN_DATA : OWN_INSTR;
        push_slot.is_write = data_gnt_o & data_we_i;
    end

    // A pending fetch that was not granted can only have lost to data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (!instr_req_i || instr_gnt_o) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    mem_arb_resp_pipe #(
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk_i          (clk_i),
        .clr_i          (rst_i),
        .push_i         (push_slot),
        .mem_rdata_i    (mem_rdata_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o)
    );

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_o    <= '0;
            instr_stall_cnt_o <= '0;
        end else begin
            if (instr_req_i && data_req_i && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
            if (instr_req_i && !instr_gnt_o && (instr_stall_cnt_o != '1)) begin
                instr_stall_cnt_o <= instr_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1/2/3) share
// one stimulus; each checked scenario targets the instance whose latency it needs.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  db;
    logic [31:0] da;
    logic [31:0] dwd;

    logic        igrant [1:3];
    logic        irv    [1:3];
    logic [31:0] ird    [1:3];
    logic        dgrant [1:3];
    logic        drv    [1:3];
    logic [31:0] drd    [1:3];
    logic        men    [1:3];
    logic        mwe    [1:3];
    logic [3:0]  mbe    [1:3];
    logic [31:0] maddr  [1:3];
    logic [31:0] mwd    [1:3];
    logic [31:0] mrd    [1:3];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] conf_cnt  [1:3];
    logic [31:0] stall_cnt [1:3];
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MEM_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igrant[1]),
        .instr_rvalid_o(irv[1]), .instr_rdata_o(ird[1]),
        .data_req_i(dr), .data_we_i(dw), .data_be_i(db), .data_addr_i(da),
        .data_wdata_i(dwd), .data_gnt_o(dgrant[1]), .data_rvalid_o(drv[1]),
        .data_rdata_o(drd[1]), .mem_en_o(men[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]),
        .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1])
`ifdef MEM_ARB_PERF_CNT_EN
        , .conflict_cnt_o(conf_cnt[1]), .instr_stall_cnt_o(stall_cnt[1])
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MEM_LAT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igrant[2]),
        .instr_rvalid_o(irv[2]), .instr_rdata_o(ird[2]),
        .data_req_i(dr), .data_we_i(dw), .data_be_i(db), .data_addr_i(da),
        .data_wdata_i(dwd), .data_gnt_o(dgrant[2]), .data_rvalid_o(drv[2]),
        .data_rdata_o(drd[2]), .mem_en_o(men[2]), .mem_we_o(mwe[2]), .mem_be_o(mbe[2]),
        .mem_addr_o(maddr[2]), .mem_wdata_o(mwd[2]), .mem_rdata_i(mrd[2])
`ifdef MEM_ARB_PERF_CNT_EN
        , .conflict_cnt_o(conf_cnt[2]), .instr_stall_cnt_o(stall_cnt[2])
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MEM_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igrant[3]),
        .instr_rvalid_o(irv[3]), .instr_rdata_o(ird[3]),
        .data_req_i(dr), .data_we_i(dw), .data_be_i(db), .data_addr_i(da),
        .data_wdata_i(dwd), .data_gnt_o(dgrant[3]), .data_rvalid_o(drv[3]),
        .data_rdata_o(drd[3]), .mem_en_o(men[3]), .mem_we_o(mwe[3]), .mem_be_o(mbe[3]),
        .mem_addr_o(maddr[3]), .mem_wdata_o(mwd[3]), .mem_rdata_i(mrd[3])
`ifdef MEM_ARB_PERF_CNT_EN
        , .conflict_cnt_o(conf_cnt[3]), .instr_stall_cnt_o(stall_cnt[3])
`endif
    );

    // Memory contents: one fixed instruction word, otherwise derived from the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'h0010_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] a1_q;
    logic [31:0] a2_q [2];
    logic [31:0] a3_q [3];

    always_ff @(posedge clk) begin
        a1_q    <= maddr[1];
        a2_q[0] <= maddr[2];
        a2_q[1] <= a2_q[0];
        a3_q[0] <= maddr[3];
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end

    always_comb begin
        mrd[1] = mem_f(a1_q);
        mrd[2] = mem_f(a2_q[1]);
        mrd[3] = mem_f(a3_q[2]);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        ir = 1'b0; ia = '0; dr = 1'b0; dw = 1'b0; db = '0; da = '0; dwd = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  db;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic        een;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ervi;
        logic        ervd;
        logic [31:0] erdi;
        logic [31:0] erdd;
    } vec_t;

    vec_t tbl [12];

    logic seq_i [12];
    logic [3:0] seq_w [12];

    initial begin
        // MEM_LAT=1 vectors; expected rvalid/rdata columns are the response to the previous row.
        tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b1, 4'h3, 32'h500, 32'h55,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 32'h0010_0093, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF,
                    1'b0, 1'b0, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h44,  32'h1234_5678,
                    1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h44,  32'h1234_5678,
                    1'b0, 1'b0, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 32'h8,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h8,   32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0044_FFBB};
        tbl[7]  = '{1'b1, 32'hC,   1'b1, 1'b1, 4'h3, 32'h300, 32'hA5A5_A5A5,
                    1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h300, 32'hA5A5_A5A5,
                    1'b1, 1'b0, 32'h0008_FFF7, 32'h0};
        tbl[8]  = '{1'b1, 32'hC,   1'b0, 1'b1, 4'h3, 32'h0,   32'h77,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'hC,   32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'h5, 32'h10,  32'h0F0F_0F0F,
                    1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 32'h10,  32'h0F0F_0F0F,
                    1'b1, 1'b0, 32'h000C_FFF3, 32'h0};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0};

        seq_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        seq_w = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

        // Reset with both requests asserted: nothing may be granted or driven.
        set_idle();
        rst = 1'b1;
        ir = 1'b1; ia = 32'h40; dr = 1'b1; da = 32'h80; db = 4'hF;
        next_cycle();
        @(negedge clk);
        chk1 ("rst_instr_gnt", igrant[1], 1'b0);
        chk1 ("rst_data_gnt",  dgrant[1], 1'b0);
        chk1 ("rst_mem_en",    men[1],    1'b0);
        chk32("rst_mem_addr",  maddr[1],  32'h0);
        chk32("rst_mem_be",    32'(mbe[1]), 32'h0);
        chk1 ("rst_instr_rv",  irv[1],    1'b0);
        chk1 ("rst_data_rv",   drv[1],    1'b0);
        chk32("rst_wait_cnt",  32'(u_dut1.wait_cnt), 32'h0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk32("rst_conflict_cnt", conf_cnt[1], 32'h0);
        chk32("rst_stall_cnt",    stall_cnt[1], 32'h0);
`endif
        next_cycle();
        rst = 1'b0;
        set_idle();

        for (int i = 0; i < 12; i++) begin
            ir = tbl[i].ir; ia = tbl[i].ia; dr = tbl[i].dr; dw = tbl[i].dw;
            db = tbl[i].db; da = tbl[i].da; dwd = tbl[i].dwd;
            @(negedge clk);
            chk1 ($sformatf("v%0d_instr_gnt", i), igrant[1], tbl[i].eig);
            chk1 ($sformatf("v%0d_data_gnt", i),  dgrant[1], tbl[i].edg);
            chk1 ($sformatf("v%0d_mem_en", i),    men[1],    tbl[i].een);
            chk1 ($sformatf("v%0d_mem_we", i),    mwe[1],    tbl[i].ewe);
            chk32($sformatf("v%0d_mem_be", i),    32'(mbe[1]), 32'(tbl[i].ebe));
            chk32($sformatf("v%0d_mem_addr", i),  maddr[1],  tbl[i].ea);
            chk32($sformatf("v%0d_mem_wdata", i), mwd[1],    tbl[i].ewd);
            chk1 ($sformatf("v%0d_instr_rv", i),  irv[1],    tbl[i].ervi);
            chk1 ($sformatf("v%0d_data_rv", i),   drv[1],    tbl[i].ervd);
            chk32($sformatf("v%0d_instr_rd", i),  ird[1],    tbl[i].erdi);
            chk32($sformatf("v%0d_data_rd", i),   drd[1],    tbl[i].erdd);
            next_cycle();
        end

        // Starvation bound: both requests held for 12 cycles after a fresh reset.
        set_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        ir = 1'b1; ia = 32'h20; dr = 1'b1; dw = 1'b0; db = 4'hF; da = 32'h60;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk1 ($sformatf("starve%0d_instr_gnt", k), igrant[1], seq_i[k]);
            chk1 ($sformatf("starve%0d_data_gnt", k),  dgrant[1], ~seq_i[k]);
            chk32($sformatf("starve%0d_wait_cnt", k),  32'(u_dut1.wait_cnt), 32'(seq_w[k]));
`ifdef MEM_ARB_PERF_CNT_EN
            if (k == 10) begin
                chk32("perf_conflict_cnt", conf_cnt[1], 32'd10);
                chk32("perf_stall_cnt",    stall_cnt[1], 32'd8);
            end
`endif
            next_cycle();
        end
        set_idle();
        repeat (5) next_cycle();

        // Owner routing at MEM_LAT=3: I@0x0, D-load@0x40, I@0x4 back to back.
        for (int c = 0; c < 7; c++) begin
            set_idle();
            if (c == 0) begin ir = 1'b1; ia = 32'h0; end
            if (c == 1) begin dr = 1'b1; da = 32'h40; db = 4'hF; dwd = 32'h0; end
            if (c == 2) begin ir = 1'b1; ia = 32'h4; end
            @(negedge clk);
            chk1 ($sformatf("lat3_c%0d_instr_gnt", c), igrant[3], (c == 0) || (c == 2));
            chk1 ($sformatf("lat3_c%0d_data_gnt", c),  dgrant[3], c == 1);
            chk1 ($sformatf("lat3_c%0d_mem_en", c),    men[3],    c < 3);
            chk1 ($sformatf("lat3_c%0d_mem_we", c),    mwe[3],    1'b0);
            chk32($sformatf("lat3_c%0d_mem_be", c),    32'(mbe[3]), (c < 3) ? 32'hF : 32'h0);
            chk32($sformatf("lat3_c%0d_mem_wdata", c), mwd[3],    32'h0);
            chk1 ($sformatf("lat3_c%0d_instr_rv", c),  irv[3],    (c == 3) || (c == 5));
            chk1 ($sformatf("lat3_c%0d_data_rv", c),   drv[3],    c == 4);
            chk32($sformatf("lat3_c%0d_instr_rd", c),  ird[3],
                  (c == 3) ? 32'h0000_FFFF : ((c == 5) ? 32'h0004_FFFB : 32'h0));
            chk32($sformatf("lat3_c%0d_data_rd", c),   drd[3],
                  (c == 4) ? 32'h0040_FFBF : 32'h0);
            next_cycle();
        end

        // Reset the cycle after a MEM_LAT=2 load grant: that load must never return.
        set_idle();
        dr = 1'b1; da = 32'h80; db = 4'hF;
        @(negedge clk);
        chk1("midrst_load_gnt", dgrant[2], 1'b1);
        next_cycle();
        rst = 1'b1;
        dr = 1'b1; da = 32'h90; dw = 1'b1; dwd = 32'h1111_2222;
        ir = 1'b1; ia = 32'h30;
        @(negedge clk);
        chk1 ("midrst_instr_gnt", igrant[2], 1'b0);
        chk1 ("midrst_data_gnt",  dgrant[2], 1'b0);
        chk1 ("midrst_mem_en",    men[2],    1'b0);
        chk1 ("midrst_mem_we",    mwe[2],    1'b0);
        chk32("midrst_mem_be",    32'(mbe[2]), 32'h0);
        chk32("midrst_mem_addr",  maddr[2],  32'h0);
        chk32("midrst_mem_wdata", mwd[2],    32'h0);
        chk1 ("midrst_instr_rv",  irv[2],    1'b0);
        chk1 ("midrst_data_rv",   drv[2],    1'b0);
        chk32("midrst_instr_rd",  ird[2],    32'h0);
        chk32("midrst_data_rd",   drd[2],    32'h0);
        next_cycle();
        rst = 1'b0;
        set_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("postrst%0d_data_rv", c),  drv[2], 1'b0);
            chk1($sformatf("postrst%0d_instr_rv", c), irv[2], 1'b0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
